// File: rtl/weighted_neighbor_link.sv
// Runtime-weighted union-find edge: growth against a per-round length, root exchange, odd status.
// Optional erasure input enabled by defining WEIGHTED_LINK_ERASURE_EN.
module weighted_neighbor_link #(
  parameter  int ADDRESS_WIDTH = 12,
  parameter  int MAX_LENGTH    = 8,
  parameter  int IS_BOUNDARY   = 0,
  localparam int LENGTH_WIDTH  = $clog2(MAX_LENGTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_initialize,
  input  logic [LENGTH_WIDTH-1:0]  i_length_in,
`ifdef WEIGHTED_LINK_ERASURE_EN
  input  logic                     i_erasure,
`endif
  input  logic                     i_a_increase,
  input  logic                     i_b_increase,
  input  logic                     i_a_is_odd_cluster,
  input  logic                     i_b_is_odd_cluster,
  input  logic [ADDRESS_WIDTH-1:0] i_a_old_root_in,
  input  logic [ADDRESS_WIDTH-1:0] i_b_old_root_in,
  output logic [ADDRESS_WIDTH-1:0] o_a_old_root_out,
  output logic [ADDRESS_WIDTH-1:0] o_b_old_root_out,
  output logic [LENGTH_WIDTH-1:0]  o_growth,
  output logic [LENGTH_WIDTH-1:0]  o_length_out,
  output logic                     o_is_fully_grown,
  output logic                     o_is_odd_cluster,
  output logic                     o_grown_pulse
);

  typedef enum logic [1:0] {IDLE = 2'd0, GROWING = 2'd1, GROWN = 2'd2} state_t;

  localparam logic [LENGTH_WIDTH-1:0] LP_MAX_LEN = LENGTH_WIDTH'(MAX_LENGTH);

  state_t                   r_state,  w_state_nxt;
  logic [LENGTH_WIDTH-1:0]  r_growth, w_growth_nxt;
  logic [LENGTH_WIDTH-1:0]  r_length, w_length_nxt;
  logic [ADDRESS_WIDTH-1:0] r_a_root, w_a_root_nxt;
  logic [ADDRESS_WIDTH-1:0] r_b_root, w_b_root_nxt;
  logic                     r_odd,    w_odd_nxt;
  logic                     r_pulse,  w_pulse_nxt;

  logic                     w_erasure;
  logic                     w_b_inc;
  logic                     w_b_odd;
  logic [ADDRESS_WIDTH-1:0] w_b_root_in;
  logic [LENGTH_WIDTH-1:0]  w_len_load;
  logic [LENGTH_WIDTH:0]    w_sum;

`ifdef WEIGHTED_LINK_ERASURE_EN
  assign w_erasure = i_erasure;
`else
  assign w_erasure = 1'b0;
`endif

  // The virtual boundary never grows, never has odd parity and has no root.
  assign w_b_inc     = (IS_BOUNDARY != 0) ? 1'b0 : i_b_increase;
  assign w_b_odd     = (IS_BOUNDARY != 0) ? 1'b0 : i_b_is_odd_cluster;
  assign w_b_root_in = (IS_BOUNDARY != 0) ? '0   : i_b_old_root_in;

  assign w_len_load = (i_length_in > LP_MAX_LEN) ? LP_MAX_LEN : i_length_in;
  // One extra bit so a+b at MAX_LENGTH-1 cannot wrap before the clamp.
  assign w_sum = {1'b0, r_growth} + {{LENGTH_WIDTH{1'b0}}, i_a_increase}
               + {{LENGTH_WIDTH{1'b0}}, w_b_inc};

  always_comb begin
    w_state_nxt  = r_state;
    w_growth_nxt = r_growth;
    w_length_nxt = r_length;
    w_a_root_nxt = r_a_root;
    w_b_root_nxt = r_b_root;
    w_odd_nxt    = r_odd;
    w_pulse_nxt  = 1'b0;
    if (i_initialize) begin
      w_length_nxt = w_len_load;
      w_a_root_nxt = '0;
      w_b_root_nxt = '0;
      w_odd_nxt    = 1'b0;
      if ((w_len_load == '0) || w_erasure) begin
        w_state_nxt  = GROWN;
        w_growth_nxt = w_len_load;
        w_pulse_nxt  = 1'b1;
      end else begin
        w_state_nxt  = GROWING;
        w_growth_nxt = '0;
      end
    end else begin
      case (r_state)
        GROWING: begin
          w_a_root_nxt = w_b_root_in;
          w_b_root_nxt = i_a_old_root_in;
          w_odd_nxt    = 1'b0;
          if (w_sum >= {1'b0, r_length}) begin
            w_growth_nxt = r_length;
            w_state_nxt  = GROWN;
            w_pulse_nxt  = 1'b1;
          end else begin
            w_growth_nxt = w_sum[LENGTH_WIDTH-1:0];
          end
        end
        GROWN: begin
          w_a_root_nxt = w_b_root_in;
          w_b_root_nxt = i_a_old_root_in;
          w_odd_nxt    = i_a_is_odd_cluster | w_b_odd;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_growth <= '0;
      r_length <= '0;
      r_a_root <= '0;
      r_b_root <= '0;
      r_odd    <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_growth <= w_growth_nxt;
      r_length <= w_length_nxt;
      r_a_root <= w_a_root_nxt;
      r_b_root <= w_b_root_nxt;
      r_odd    <= w_odd_nxt;
      r_pulse  <= w_pulse_nxt;
    end
  end

  assign o_a_old_root_out = r_a_root;
  assign o_b_old_root_out = r_b_root;
  assign o_growth         = r_growth;
  assign o_length_out     = r_length;
  assign o_is_fully_grown = (r_state != IDLE) && (r_growth >= r_length);
  assign o_is_odd_cluster = r_odd;
  assign o_grown_pulse    = r_pulse;

endmodule

// File: tb/tb_weighted_neighbor_link.sv
// Directed bench for weighted_neighbor_link: an interior edge and a boundary edge share stimulus.
module tb_weighted_neighbor_link;
  localparam int AW = 12;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset, initialize, erasure;
  logic [LW-1:0] length_in;
  logic          a_inc, b_inc, a_odd, b_odd;
  logic [AW-1:0] a_root_in, b_root_in;

  logic [AW-1:0] a_root_out, b_root_out, bd_a_root_out, bd_b_root_out;
  logic [LW-1:0] growth, length_out, bd_growth, bd_length_out;
  logic          full, odd, pulse, bd_full, bd_odd, bd_pulse;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weighted_neighbor_link #(.ADDRESS_WIDTH(AW), .MAX_LENGTH(8), .IS_BOUNDARY(0)) dut (
    .i_clk(clk), .i_reset(reset), .i_initialize(initialize), .i_length_in(length_in),
`ifdef WEIGHTED_LINK_ERASURE_EN
    .i_erasure(erasure),
`endif
    .i_a_increase(a_inc), .i_b_increase(b_inc),
    .i_a_is_odd_cluster(a_odd), .i_b_is_odd_cluster(b_odd),
    .i_a_old_root_in(a_root_in), .i_b_old_root_in(b_root_in),
    .o_a_old_root_out(a_root_out), .o_b_old_root_out(b_root_out),
    .o_growth(growth), .o_length_out(length_out), .o_is_fully_grown(full),
    .o_is_odd_cluster(odd), .o_grown_pulse(pulse));

  weighted_neighbor_link #(.ADDRESS_WIDTH(AW), .MAX_LENGTH(8), .IS_BOUNDARY(1)) dut_bd (
    .i_clk(clk), .i_reset(reset), .i_initialize(initialize), .i_length_in(length_in),
`ifdef WEIGHTED_LINK_ERASURE_EN
    .i_erasure(erasure),
`endif
    .i_a_increase(a_inc), .i_b_increase(b_inc),
    .i_a_is_odd_cluster(a_odd), .i_b_is_odd_cluster(b_odd),
    .i_a_old_root_in(a_root_in), .i_b_old_root_in(b_root_in),
    .o_a_old_root_out(bd_a_root_out), .o_b_old_root_out(bd_b_root_out),
    .o_growth(bd_growth), .o_length_out(bd_length_out), .o_is_fully_grown(bd_full),
    .o_is_odd_cluster(bd_odd), .o_grown_pulse(bd_pulse));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; initialize = 1'b0; erasure = 1'b0; length_in = '0;
    a_inc = 1'b0; b_inc = 1'b0; a_odd = 1'b0; b_odd = 1'b0;
    a_root_in = '0; b_root_in = '0;
  endtask

  // Status vector layout: {growth, length_out, full, odd, pulse}
  task automatic test_reset();
    logic [LW*2+2:0] exp;
    idle_inputs();
    reset = 1'b1; a_inc = 1'b1; a_root_in = 12'h5A5;
    step(); step();
    exp = '0;
    n_vec++;
    if ({growth, length_out, full, odd, pulse} !== exp) begin
      n_err++; $display("FAIL reset_status got=%h exp=%h", {growth, length_out, full, odd, pulse}, exp);
    end
    n_vec++;
    if ({a_root_out, b_root_out} !== 24'h0) begin
      n_err++; $display("FAIL reset_roots got=%h exp=0", {a_root_out, b_root_out});
    end
    reset = 1'b0;
    step();
    n_vec++;
    if ({growth, full, pulse} !== 6'h0) begin
      n_err++; $display("FAIL idle_ignores_inc got=%h exp=0", {growth, full, pulse});
    end
  endtask

  task automatic test_single_growth();
    logic [LW-1:0] exp_g;
    idle_inputs();
    length_in = 4'd4; initialize = 1'b1; a_odd = 1'b1;
    a_root_in = 12'h123; b_root_in = 12'h456;
    step();
    initialize = 1'b0;
    n_vec++;
    if ({growth, length_out, full, pulse, a_root_out} !== {4'd0, 4'd4, 1'b0, 1'b0, 12'h000}) begin
      n_err++; $display("FAIL init_len4 got g=%0d l=%0d f=%b p=%b ar=%h exp g=0 l=4 f=0 p=0 ar=0",
                        growth, length_out, full, pulse, a_root_out);
    end
    a_inc = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_g = LW'(i);
      n_vec++;
      if ({growth, full, odd, pulse} !== {exp_g, (i == 4), 1'b0, (i == 4)}) begin
        n_err++; $display("FAIL a_step%0d got g=%0d f=%b o=%b p=%b exp g=%0d f=%b o=0 p=%b",
                          i, growth, full, odd, pulse, exp_g, (i == 4), (i == 4));
      end
    end
    n_vec++;
    if ({a_root_out, b_root_out} !== {12'h456, 12'h123}) begin
      n_err++; $display("FAIL root_swap got=%h exp=456123", {a_root_out, b_root_out});
    end
    step();
    n_vec++;
    if ({growth, full, odd, pulse} !== {4'd4, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL grown_odd got g=%0d f=%b o=%b p=%b exp g=4 f=1 o=1 p=0",
                        growth, full, odd, pulse);
    end
    a_inc = 1'b0;
  endtask

  task automatic test_saturate();
    int pulses;
    idle_inputs();
    length_in = 4'd3; initialize = 1'b1;
    step();
    initialize = 1'b0; a_inc = 1'b1; b_inc = 1'b1;
    pulses = 0;
    step();
    pulses += int'(pulse);
    n_vec++;
    if (growth !== 4'd2) begin
      n_err++; $display("FAIL sat_first got=%0d exp=2", growth);
    end
    step();
    pulses += int'(pulse);
    n_vec++;
    if ({growth, full} !== {4'd3, 1'b1}) begin
      n_err++; $display("FAIL sat_clamp got g=%0d f=%b exp g=3 f=1", growth, full);
    end
    step();
    pulses += int'(pulse);
    step();
    pulses += int'(pulse);
    n_vec++;
    if (growth !== 4'd3 || pulses != 1) begin
      n_err++; $display("FAIL sat_single_pulse got g=%0d pulses=%0d exp g=3 pulses=1", growth, pulses);
    end
  endtask

  task automatic test_zero_and_clamp();
    idle_inputs();
    length_in = 4'd0; initialize = 1'b1; a_inc = 1'b1;
    step();
    initialize = 1'b0;
    n_vec++;
    if ({growth, length_out, full, pulse} !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL zero_len got g=%0d l=%0d f=%b p=%b exp g=0 l=0 f=1 p=1",
                        growth, length_out, full, pulse);
    end
    b_inc = 1'b1;
    step();
    n_vec++;
    if ({growth, full, pulse} !== {4'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL zero_hold got g=%0d f=%b p=%b exp g=0 f=1 p=0", growth, full, pulse);
    end
    idle_inputs();
    length_in = 4'd12; initialize = 1'b1;
    step();
    n_vec++;
    if ({growth, length_out, full, pulse} !== {4'd0, 4'd8, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL clamp12 got g=%0d l=%0d f=%b p=%b exp g=0 l=8 f=0 p=0",
                        growth, length_out, full, pulse);
    end
    initialize = 1'b0; a_inc = 1'b1; b_inc = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if ({growth, full, pulse} !== {4'd8, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL max_len_grown got g=%0d f=%b p=%b exp g=8 f=1 p=1", growth, full, pulse);
    end
  endtask

  task automatic test_erasure();
`ifdef WEIGHTED_LINK_ERASURE_EN
    idle_inputs();
    length_in = 4'd5; initialize = 1'b1; erasure = 1'b1;
    step();
    initialize = 1'b0; erasure = 1'b0;
    n_vec++;
    if ({growth, length_out, full, pulse} !== {4'd5, 4'd5, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL erasure got g=%0d l=%0d f=%b p=%b exp g=5 l=5 f=1 p=1",
                        growth, length_out, full, pulse);
    end
`endif
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    length_in = 4'd5; initialize = 1'b1;
    step();
    n_vec++;
    if (length_out !== 4'd5) begin
      n_err++; $display("FAIL b2b_first got=%0d exp=5", length_out);
    end
    length_in = 4'd2; a_inc = 1'b1;
    step();
    n_vec++;
    if ({growth, length_out} !== {4'd0, 4'd2}) begin
      n_err++; $display("FAIL b2b_second got g=%0d l=%0d exp g=0 l=2", growth, length_out);
    end
    initialize = 1'b0;
  endtask

  task automatic test_boundary();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    length_in = 4'd2; initialize = 1'b1; b_inc = 1'b1; b_odd = 1'b1;
    a_root_in = 12'h111; b_root_in = 12'hABC;
    step();
    initialize = 1'b0;
    step();
    n_vec++;
    if ({bd_growth, bd_full} !== {4'd0, 1'b0}) begin
      n_err++; $display("FAIL bd_b_ignored got g=%0d f=%b exp g=0 f=0", bd_growth, bd_full);
    end
    a_inc = 1'b1;
    step();
    n_vec++;
    if ({bd_growth, bd_pulse} !== {4'd1, 1'b0}) begin
      n_err++; $display("FAIL bd_a_step1 got g=%0d p=%b exp g=1 p=0", bd_growth, bd_pulse);
    end
    step();
    n_vec++;
    if ({bd_growth, bd_full, bd_pulse} !== {4'd2, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL bd_a_step2 got g=%0d f=%b p=%b exp g=2 f=1 p=1", bd_growth, bd_full, bd_pulse);
    end
    a_inc = 1'b0;
    step();
    n_vec++;
    if ({bd_odd, bd_a_root_out, bd_b_root_out} !== {1'b0, 12'h000, 12'h111}) begin
      n_err++; $display("FAIL bd_odd_roots got o=%b ar=%h br=%h exp o=0 ar=000 br=111",
                        bd_odd, bd_a_root_out, bd_b_root_out);
    end
    n_vec++;
    if (odd !== 1'b1) begin
      n_err++; $display("FAIL interior_b_odd got=%b exp=1", odd);
    end
  endtask

  task automatic test_reset_mid_growth();
    logic [LW*2+2:0] exp;
    idle_inputs();
    length_in = 4'd6; initialize = 1'b1;
    step();
    initialize = 1'b0; a_inc = 1'b1;
    step(); step();
    n_vec++;
    if (growth !== 4'd2) begin
      n_err++; $display("FAIL mid_growth got=%0d exp=2", growth);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp = '0;
    n_vec++;
    if ({growth, length_out, full, odd, pulse, a_root_out, b_root_out} !== {exp, 24'h0}) begin
      n_err++; $display("FAIL reset_mid got=%h exp=0", {growth, length_out, full, odd, pulse, a_root_out, b_root_out});
    end
    step();
    n_vec++;
    if ({growth, full} !== {4'd0, 1'b0}) begin
      n_err++; $display("FAIL post_reset_inc got g=%0d f=%b exp g=0 f=0", growth, full);
    end
    length_in = 4'd6; initialize = 1'b1;
    step();
    initialize = 1'b0;
    n_vec++;
    if (growth !== 4'd0) begin
      n_err++; $display("FAIL init_with_inc got=%0d exp=0", growth);
    end
    step();
    n_vec++;
    if (growth !== 4'd1) begin
      n_err++; $display("FAIL after_init_inc got=%0d exp=1", growth);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_growth();
    test_saturate();
    test_zero_and_clamp();
    test_erasure();
    test_back_to_back();
    test_boundary();
    test_reset_mid_growth();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
